// File: rtl/comm_pkg.sv
// Shared definitions for the remote command link: FSM states, 8N1 framing constants and
// the opcodes used by benches.
package comm_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StTxCmd,
    StTxHi,
    StTxLo,
    StWaitResp
  } state_e;

  localparam logic START = 1'b0;
  localparam logic STOP  = 1'b1;
  localparam int unsigned BITS_PER_FRAME = 10;

  localparam int unsigned DEFAULT_BAUD_DIV     = 2604;
  localparam int unsigned DEFAULT_RESP_TIMEOUT = 4194304;

  localparam logic [7:0] OP_NOP      = 8'h00;
  localparam logic [7:0] OP_SET_PTCH = 8'h02;
  localparam logic [7:0] OP_SET_ROLL = 8'h03;
  localparam logic [7:0] OP_SET_YAW  = 8'h04;
  localparam logic [7:0] OP_THRST    = 8'h05;
  localparam logic [7:0] OP_CALIBRATE = 8'h06;

endpackage

// File: rtl/uart_tx.sv
// 8N1 byte serializer. A trmt during the last stop-bit clock reloads directly, so
// consecutive bytes go out with no idle gap.
module uart_tx
  import comm_pkg::*;
#(
  parameter int unsigned BAUD_DIV = DEFAULT_BAUD_DIV
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       trmt,
  input  logic [7:0] tx_data,
  output logic       TX,
  output logic       tx_done
);

  localparam int unsigned BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
  localparam logic [3:0] STOP_IDX = 4'(BITS_PER_FRAME - 1);

  logic [BW-1:0] baud_cnt;
  logic [3:0]    bit_cnt;
  logic [8:0]    shift;
  logic          active;

  assign tx_done = active && (baud_cnt == BAUD_LAST) && (bit_cnt == STOP_IDX);

  always_ff @(posedge clk) begin
    if (rst) begin
      active   <= 1'b0;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '1;
      TX       <= STOP;
    end else if (trmt) begin
      active   <= 1'b1;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= {STOP, tx_data};
      TX       <= START;
    end else if (active) begin
      if (baud_cnt == BAUD_LAST) begin
        baud_cnt <= '0;
        if (bit_cnt == STOP_IDX) begin
          active  <= 1'b0;
          bit_cnt <= '0;
          TX      <= STOP;
        end else begin
          bit_cnt <= bit_cnt + 4'd1;
          TX      <= shift[0];
          shift   <= {STOP, shift[8:1]};
        end
      end else begin
        baud_cnt <= baud_cnt + BW'(1);
      end
    end
  end

endmodule

// File: rtl/remote_comm.sv
// Host end of the copter command link: sends {cmd, data[15:8], data[7:0]} as three 8N1
// bytes, then waits for one response byte or a timeout.
module remote_comm
  import comm_pkg::*;
#(
  parameter int unsigned BAUD_DIV     = DEFAULT_BAUD_DIV,
  parameter int unsigned RESP_TIMEOUT = DEFAULT_RESP_TIMEOUT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        snd_cmd,
  input  logic [7:0]  cmd,
  input  logic [15:0] data,
  input  logic        RX,
  output logic        TX,
  output logic        busy,
  output logic        resp_rdy,
  output logic [7:0]  resp,
  output logic        timeout,
  output logic        cmd_sent
);

  localparam int unsigned BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int unsigned TW = (RESP_TIMEOUT > 1) ? $clog2(RESP_TIMEOUT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
  localparam logic [BW-1:0] HALF_LAST = BW'(BAUD_DIV / 2 - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(RESP_TIMEOUT - 1);
  localparam logic [3:0]    STOP_IDX  = 4'(BITS_PER_FRAME - 1);

  state_e      state;
  logic [23:0] shadow;
  logic [TW-1:0] to_cnt;

  logic       trmt;
  logic [7:0] tx_data;
  logic       tx_done;

  // Next byte is launched combinationally so the serializer starts it without a gap.
  always_comb begin
    trmt    = 1'b0;
    tx_data = shadow[23:16];
    case (state)
      StIdle: begin
        trmt    = snd_cmd;
        tx_data = cmd;
      end
      StTxCmd: begin
        trmt    = tx_done;
        tx_data = shadow[15:8];
      end
      StTxHi: begin
        trmt    = tx_done;
        tx_data = shadow[7:0];
      end
      default: ;
    endcase
  end

  uart_tx #(
    .BAUD_DIV(BAUD_DIV)
  ) u_uart_tx (
    .clk    (clk),
    .rst    (rst),
    .trmt   (trmt),
    .tx_data(tx_data),
    .TX     (TX),
    .tx_done(tx_done)
  );

  // Receiver: active only in StWaitResp, sampling mid-bit from the synchronized line.
  logic          rx_ff1, rx_ff2, rx_prev;
  logic          rx_active;
  logic [BW-1:0] rx_baud;
  logic [3:0]    rx_bit;
  logic [7:0]    rx_shift;
  logic          rx_en, rx_fall, rx_tick, rx_done;

  assign rx_en   = (state == StWaitResp);
  assign rx_fall = rx_prev & ~rx_ff2;
  assign rx_tick = rx_active && (rx_baud == ((rx_bit == 4'd0) ? HALF_LAST : BAUD_LAST));
  assign rx_done = rx_en && rx_tick && (rx_bit == STOP_IDX) && (rx_ff2 == STOP);

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_ff1    <= 1'b1;
      rx_ff2    <= 1'b1;
      rx_prev   <= 1'b1;
      rx_active <= 1'b0;
      rx_baud   <= '0;
      rx_bit    <= '0;
      rx_shift  <= '0;
    end else begin
      rx_ff1  <= RX;
      rx_ff2  <= rx_ff1;
      rx_prev <= rx_ff2;
      if (!rx_en) begin
        rx_active <= 1'b0;
        rx_baud   <= '0;
        rx_bit    <= '0;
      end else if (!rx_active) begin
        if (rx_fall) begin
          rx_active <= 1'b1;
          rx_baud   <= '0;
          rx_bit    <= '0;
        end
      end else if (rx_tick) begin
        rx_baud <= '0;
        // A start bit that reads high at its midpoint was a glitch; a stop bit ends the frame.
        if ((rx_bit == 4'd0 && rx_ff2 != START) || rx_bit == STOP_IDX) begin
          rx_active <= 1'b0;
          rx_bit    <= '0;
        end else begin
          rx_bit <= rx_bit + 4'd1;
          if (rx_bit != 4'd0) rx_shift <= {rx_ff2, rx_shift[7:1]};
        end
      end else begin
        rx_baud <= rx_baud + BW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= StIdle;
      shadow   <= '0;
      to_cnt   <= '0;
      busy     <= 1'b0;
      resp     <= 8'h00;
      resp_rdy <= 1'b0;
      timeout  <= 1'b0;
      cmd_sent <= 1'b0;
    end else begin
      resp_rdy <= 1'b0;
      timeout  <= 1'b0;
      cmd_sent <= 1'b0;
      case (state)
        StIdle: begin
          if (snd_cmd) begin
            shadow <= {cmd, data};
            busy   <= 1'b1;
            state  <= StTxCmd;
          end
        end
        StTxCmd: if (tx_done) state <= StTxHi;
        StTxHi:  if (tx_done) state <= StTxLo;
        StTxLo: begin
          if (tx_done) begin
            cmd_sent <= 1'b1;
            to_cnt   <= '0;
            state    <= StWaitResp;
          end
        end
        StWaitResp: begin
          // Reception takes priority over a simultaneous timeout.
          if (rx_done) begin
            resp     <= rx_shift;
            resp_rdy <= 1'b1;
            busy     <= 1'b0;
            to_cnt   <= '0;
            state    <= StIdle;
          end else if (to_cnt == TO_LAST) begin
            timeout <= 1'b1;
            busy    <= 1'b0;
            to_cnt  <= '0;
            state   <= StIdle;
          end else begin
            to_cnt <= to_cnt + TW'(1);
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_remote_comm.sv
// Directed bench for remote_comm with BAUD_DIV=8, RESP_TIMEOUT=2000.
module tb_remote_comm;

  logic        clk = 1'b0;
  logic        rst;
  logic        snd_cmd;
  logic [7:0]  cmd;
  logic [15:0] data;
  logic        RX;
  logic        TX;
  logic        busy;
  logic        resp_rdy;
  logic [7:0]  resp;
  logic        timeout;
  logic        cmd_sent;

  int checks = 0;
  int errors = 0;

  int n_rdy  = 0;
  int n_to   = 0;
  int n_sent = 0;
  logic busy_at_rdy = 1'b1;

  logic [239:0] cap;
  logic [239:0] exp_wave;

  remote_comm #(
    .BAUD_DIV    (8),
    .RESP_TIMEOUT(2000)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .snd_cmd (snd_cmd),
    .cmd     (cmd),
    .data    (data),
    .RX      (RX),
    .TX      (TX),
    .busy    (busy),
    .resp_rdy(resp_rdy),
    .resp    (resp),
    .timeout (timeout),
    .cmd_sent(cmd_sent)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (resp_rdy) begin
      n_rdy       <= n_rdy + 1;
      busy_at_rdy <= busy;
    end
    if (timeout)  n_to   <= n_to + 1;
    if (cmd_sent) n_sent <= n_sent + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected TX waveform, one sample per clock, for three 8N1 bytes at 8 clocks per bit.
  function automatic logic [239:0] build_wave(input logic [7:0] b0, b1, b2);
    logic [239:0] w;
    logic [7:0]   b;
    logic         v;
    w = '1;
    for (int k = 0; k < 3; k++) begin
      b = (k == 0) ? b0 : (k == 1) ? b1 : b2;
      for (int j = 0; j < 10; j++) begin
        v = (j == 0) ? 1'b0 : (j == 9) ? 1'b1 : b[j-1];
        for (int s = 0; s < 8; s++) w[k*80 + j*8 + s] = v;
      end
    end
    return w;
  endfunction

  // Issue snd_cmd and record TX for the 240 cycles that follow; optionally re-pulse snd_cmd.
  task automatic send_and_capture(input logic [7:0] c, input logic [15:0] d, input int inject_at);
    step();
    snd_cmd = 1'b1;
    cmd     = c;
    data    = d;
    for (int i = 0; i < 240; i++) begin
      step();
      cap[i]  = TX;
      snd_cmd = (i == inject_at);
      cmd     = (i == inject_at) ? 8'hFF : 8'hC3;
      data    = (i == inject_at) ? 16'hFFFF : 16'h5A5A;
    end
    snd_cmd = 1'b0;
  endtask

  task automatic rx_send(input logic [7:0] b, input logic stop_val);
    for (int j = 0; j < 10; j++) begin
      RX = (j == 0) ? 1'b0 : (j == 9) ? stop_val : b[j-1];
      for (int s = 0; s < 8; s++) step();
    end
    RX = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    checks++;
    if (TX !== 1'b1 || busy !== 1'b0 || resp !== 8'h00 || resp_rdy !== 1'b0 ||
        timeout !== 1'b0 || cmd_sent !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: TX=%b busy=%b resp=%h rdy=%b to=%b sent=%b, required 1 0 00 0 0 0",
               TX, busy, resp, resp_rdy, timeout, cmd_sent);
    end
    // RX traffic while idle must be ignored.
    rx_send(8'h3C, 1'b1);
    for (int i = 0; i < 8; i++) step();
    checks++;
    if (n_rdy !== 0 || resp !== 8'h00) begin
      errors++;
      $display("FAIL rx_ignored_idle: n_rdy=%0d resp=%h, required 0 00", n_rdy, resp);
    end
  endtask

  task automatic test_normal();
    int sent0;
    int rdy0;
    sent0 = n_sent;
    send_and_capture(8'h02, 16'h1234, -1);
    exp_wave = build_wave(8'h02, 8'h12, 8'h34);
    checks++;
    if (cap !== exp_wave) begin
      errors++;
      $display("FAIL frame_02_12_34: got %h, required %h", cap, exp_wave);
    end
    // Hand-placed edges: start N+1..N+8, bit0(0) N+9..16, bit1(1) N+17..24, byte 2 start N+81.
    checks++;
    if (cap[7:0] !== 8'h00 || cap[15:8] !== 8'h00 || cap[23:16] !== 8'hFF || cap[24] !== 1'b0) begin
      errors++;
      $display("FAIL bit_timing_byte1: got start=%h b0=%h b1=%h b2first=%b, required 00 00 ff 0",
               cap[7:0], cap[15:8], cap[23:16], cap[24]);
    end
    checks++;
    if (cap[79] !== 1'b1 || cap[80] !== 1'b0 || cap[159] !== 1'b1 || cap[160] !== 1'b0 ||
        cap[239] !== 1'b1) begin
      errors++;
      $display("FAIL byte_boundaries: got %b%b %b%b %b, required 10 10 1",
               cap[79], cap[80], cap[159], cap[160], cap[239]);
    end
    step();
    checks++;
    if (cmd_sent !== 1'b1 || busy !== 1'b1 || TX !== 1'b1) begin
      errors++;
      $display("FAIL cmd_sent_pulse: sent=%b busy=%b TX=%b, required 1 1 1", cmd_sent, busy, TX);
    end
    rdy0 = n_rdy;
    rx_send(8'hA5, 1'b1);
    for (int i = 0; i < 8; i++) step();
    checks++;
    if (n_sent - sent0 !== 1) begin
      errors++;
      $display("FAIL cmd_sent_once: got %0d pulses, required 1", n_sent - sent0);
    end
    checks++;
    if (n_rdy - rdy0 !== 1 || resp !== 8'hA5) begin
      errors++;
      $display("FAIL resp_A5: rdy cycles=%0d resp=%h, required 1 a5", n_rdy - rdy0, resp);
    end
    checks++;
    if (busy_at_rdy !== 1'b0 || busy !== 1'b0 || resp_rdy !== 1'b0) begin
      errors++;
      $display("FAIL busy_after_resp: busy@rdy=%b busy=%b rdy=%b, required 0 0 0",
               busy_at_rdy, busy, resp_rdy);
    end
  endtask

  task automatic test_back_pressure_timeout();
    int to0;
    int t;
    logic tx_idle;
    send_and_capture(8'h02, 16'h1234, 100);
    exp_wave = build_wave(8'h02, 8'h12, 8'h34);
    checks++;
    if (cap !== exp_wave) begin
      errors++;
      $display("FAIL frame_back_pressure: got %h, required %h", cap, exp_wave);
    end
    step();
    checks++;
    if (cmd_sent !== 1'b1) begin
      errors++;
      $display("FAIL cmd_sent_bp: got %b, required 1", cmd_sent);
    end
    to0     = n_to;
    t       = -1;
    tx_idle = 1'b1;
    for (int i = 1; i <= 2100; i++) begin
      step();
      if (TX !== 1'b1) tx_idle = 1'b0;
      if (timeout === 1'b1) begin
        t = i;
        break;
      end
    end
    checks++;
    if (t !== 2000) begin
      errors++;
      $display("FAIL timeout_latency: got %0d clocks, required 2000", t);
    end
    checks++;
    if (busy !== 1'b0 || resp !== 8'hA5) begin
      errors++;
      $display("FAIL timeout_state: busy=%b resp=%h, required 0 a5", busy, resp);
    end
    for (int i = 0; i < 100; i++) begin
      step();
      if (TX !== 1'b1) tx_idle = 1'b0;
    end
    checks++;
    if (tx_idle !== 1'b1 || n_to - to0 !== 1) begin
      errors++;
      $display("FAIL no_second_frame: tx_idle=%b timeout cycles=%0d, required 1 1",
               tx_idle, n_to - to0);
    end
  endtask

  task automatic test_reset_mid_frame();
    int sent0;
    logic tx_idle;
    step();
    snd_cmd = 1'b1;
    cmd     = 8'h02;
    data    = 16'h1234;
    // Sample index 114 is cycle N+115, inside bit 3 of byte 2.
    for (int i = 0; i < 115; i++) begin
      step();
      snd_cmd = 1'b0;
    end
    sent0 = n_sent;
    rst   = 1'b1;
    step();
    rst   = 1'b0;
    checks++;
    if (TX !== 1'b1 || busy !== 1'b0 || cmd_sent !== 1'b0 || resp !== 8'h00) begin
      errors++;
      $display("FAIL reset_mid_frame: TX=%b busy=%b sent=%b resp=%h, required 1 0 0 00",
               TX, busy, cmd_sent, resp);
    end
    tx_idle = 1'b1;
    for (int i = 0; i < 300; i++) begin
      step();
      if (TX !== 1'b1) tx_idle = 1'b0;
    end
    checks++;
    if (tx_idle !== 1'b1 || n_sent !== sent0) begin
      errors++;
      $display("FAIL abandoned_frame: tx_idle=%b cmd_sent pulses=%0d, required 1 0",
               tx_idle, n_sent - sent0);
    end
    send_and_capture(8'h05, 16'hBEEF, -1);
    exp_wave = build_wave(8'h05, 8'hBE, 8'hEF);
    checks++;
    if (cap !== exp_wave) begin
      errors++;
      $display("FAIL frame_after_reset: got %h, required %h", cap, exp_wave);
    end
    step();
    checks++;
    if (cmd_sent !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL cmd_sent_after_reset: sent=%b busy=%b, required 1 1", cmd_sent, busy);
    end
  endtask

  task automatic test_framing_error();
    int rdy0;
    rdy0 = n_rdy;
    rx_send(8'h5A, 1'b0);
    for (int i = 0; i < 16; i++) step();
    checks++;
    if (n_rdy !== rdy0 || resp !== 8'h00 || busy !== 1'b1) begin
      errors++;
      $display("FAIL framing_discard: rdy cycles=%0d resp=%h busy=%b, required 0 00 1",
               n_rdy - rdy0, resp, busy);
    end
    rx_send(8'hA5, 1'b1);
    for (int i = 0; i < 8; i++) step();
    checks++;
    if (n_rdy - rdy0 !== 1 || resp !== 8'hA5 || busy !== 1'b0) begin
      errors++;
      $display("FAIL framing_recover: rdy cycles=%0d resp=%h busy=%b, required 1 a5 0",
               n_rdy - rdy0, resp, busy);
    end
  endtask

  initial begin
    rst     = 1'b1;
    snd_cmd = 1'b0;
    cmd     = 8'h00;
    data    = 16'h0000;
    RX      = 1'b1;
    test_reset();
    test_normal();
    test_back_pressure_timeout();
    test_reset_mid_frame();
    test_framing_error();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
